md_unit: RTL and testbench

Multiply/divide unit of the Execute stage in the five-stage MIPS pipeline. It executes mult/multu/div/divu over a fixed number of cycles and holds the HI/LO registers. It serves mfhi/mflo/mthi/mtlo and drives the `start`/`Busy` pair that the hazard unit uses to stall any MD-class instruction in Decode. Operands arrive already forwarded (E_Forward1/E_Forward2).

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_calc.sv | 43 ++++
 rtl/md_unit.sv | 106 ++++++++++
 tb/tb_md_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Quotient reported for any divide by zero (no trap is raised).
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  // Operations that occupy the unit for several cycles.
  function automatic logic is_arith_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Multiplies use the short latency; divides the long one.
  function automatic logic is_mul_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the {hi, lo} pair,
// including the divide-by-zero and signed-overflow results.
module md_calc
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic               b_zero;
  logic               div_ovf;

  assign sa      = a;
  assign sb      = b;
  assign b_zero  = (b == 32'h0);
  // Most negative value divided by -1 has no representable quotient.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Select the result of the requested operation.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    res = 64'h0;
    case (op)
      MD_MULT:  res = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      MD_MULTU: res = {32'h0, a} * {32'h0, b};
      MD_DIV: begin
        if (b_zero)       res = {a, DIV0_LO};
        else if (div_ovf) res = {32'h0, 32'h8000_0000};
        else              res = {sa % sb, sa / sb};
      end
      MD_DIVU: begin
        if (b_zero) res = {a, DIV0_LO};
        else        res = {a % b, a / b};
      end
      default:    res = 64'h0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: issues mult/div, holds the result
// for a fixed latency while Busy, then commits it to HI/LO. Also serves
// mfhi/mflo/mthi/mtlo.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_en,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rd
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_op_e             op_e;
  md_state_e          state_q;
  md_state_e          state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        pend_hi_q;
  logic [31:0]        pend_lo_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [63:0]        calc_res;
  logic               commit;
  logic               idle_en;

  assign op_e    = md_op_e'(md_op);
  assign Busy    = (state_q == ST_BUSY);
  assign commit  = Busy && (cnt_q == CNT_W'(1));
  assign idle_en = E_en && !Busy;
  assign HI      = hi_q;
  assign LO      = lo_q;

  md_calc u_calc (
    .op  (op_e),
    .a   (A),
    .b   (B),
    .res (calc_res)
  );

  // FSM state register.
  // NOTE: sequential state is written with non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave IDLE on an issue, return when the countdown commits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_BUSY;
      ST_BUSY: if (commit) state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  // Outputs: issue strobe and move-from read port.
  always_comb begin
    start = idle_en && is_arith_op(op_e);
    md_rd = 32'h0;
    if (op_e == MD_MFHI)      md_rd = hi_q;
    else if (op_e == MD_MFLO) md_rd = lo_q;
  end

  // Latch the computed result and latency on issue; count down while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
    end else if (start) begin
      cnt_q                  <= is_mul_op(op_e) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      {pend_hi_q, pend_lo_q} <= calc_res;
    end else if (Busy) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // HI/LO: commit pending result, or accept mthi/mtlo when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else if (commit) begin
      hi_q <= pend_hi_q;
      lo_q <= pend_lo_q;
    end else if (idle_en && (op_e == MD_MTHI)) begin
      hi_q <= A;
    end else if (idle_en && (op_e == MD_MTLO)) begin
      lo_q <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal results,
// then randomized traffic compared every cycle against a reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        E_en  = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] A     = 32'h0;
  logic [31:0] B     = 32'h0;
  logic        start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_rd;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .E_en  (E_en),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .start (start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .md_rd (md_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  function automatic logic tb_is_arith(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    res = 64'h0;
    case (op)
      4'd1: res = sa * sb;
      4'd2: res = ua * ub;
      4'd3: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq  = ua / ub;
          ur  = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = 64'h0;
    endcase
    return res;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (E_en && tb_is_arith(md_op)) begin
      {m_phi, m_plo} = ref_calc(md_op, A, B);
      m_left = (md_op <= 4'd2) ? MC : DC;
    end else if (E_en && md_op == 4'd7) begin
      m_hi = A;
    end else if (E_en && md_op == 4'd8) begin
      m_lo = A;
    end
  end

  // Every mid-cycle, compare all outputs with the model.
  always @(negedge clk) begin : cmp
    logic        exp_st;
    logic [31:0] exp_rd;
    if (reset) begin
      exp_st = E_en && (m_left == 0) && tb_is_arith(md_op);
      exp_rd = (md_op == 4'd5) ? m_hi : (md_op == 4'd6) ? m_lo : 32'h0;
      check("start", 32'(start), 32'(exp_st));
      check("busy", 32'(Busy), 32'(m_left > 0));
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      check("md_rd", md_rd, exp_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive one cycle of inputs, sample start before the edge, step past it.
  task automatic cyc(input logic en, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, output logic st);
    E_en = en; md_op = op; A = a; B = b;
    #1 st = start;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wait(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_n,
                            input logic [31:0] ehi, input logic [31:0] elo);
    logic st;
    int   n;
    cyc(1'b1, op, a, b, st);
    check({name, " start"}, 32'(st), 32'd1);
    n = 0;
    while (Busy && n < 64) begin
      n++;
      cyc(1'b1, 4'd0, 32'h0, 32'h0, st);
    end
    check({name, " busy cycles"}, n, exp_n);
    check({name, " HI"}, HI, ehi);
    check({name, " LO"}, LO, elo);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic st;

    // Reset state.
    #12;
    check("reset busy", 32'(Busy), 32'd0);
    check("reset HI", HI, 32'h0);
    check("reset LO", LO, 32'h0);
    check("reset md_rd", md_rd, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(1'b1, 4'd0, 32'h0, 32'h0, st);

    // Pin the model with hand-computed results.
    issue_wait("mult -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue_wait("divu 100/7", 4'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14);
    issue_wait("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue_wait("div 5/0", 4'd3, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF);
    issue_wait("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0, 32'h8000_0000);

    // Held in E: no issue until E_en rises; one result only.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'd1, 32'h0001_0000, 32'h0001_0000, st);
      check("held no start", 32'(st), 32'd0);
    end
    issue_wait("held mult", 4'd1, 32'h0001_0000, 32'h0001_0000, MC, 32'd1, 32'd0);

    // mtlo then mflo.
    cyc(1'b1, 4'd8, 32'h1234, 32'h0, st);
    E_en = 1'b1; md_op = 4'd6;
    #1;
    check("mtlo LO", LO, 32'h1234);
    check("mflo md_rd", md_rd, 32'h1234);
    @(posedge clk);
    #1;

    // Back-to-back issue in the cycle Busy falls.
    issue_wait("b2b mult 1", 4'd1, 32'd7, 32'd6, MC, 32'd0, 32'd42);
    issue_wait("b2b multu 2", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'd1);

    // Asynchronous reset in Busy cycle 3 of a div discards the result.
    cyc(1'b1, 4'd3, 32'd1000, 32'd3, st);
    cyc(1'b1, 4'd0, 32'h0, 32'h0, st);
    cyc(1'b1, 4'd0, 32'h0, 32'h0, st);
    #1 reset = 1'b0;
    #1;
    check("async rst busy", 32'(Busy), 32'd0);
    check("async rst HI", HI, 32'h0);
    check("async rst LO", LO, 32'h0);
    #1 reset = 1'b1;
    for (int i = 0; i < DC + 3; i++) cyc(1'b1, 4'd0, 32'h0, 32'h0, st);
    check("no late commit busy", 32'(Busy), 32'd0);
    check("no late commit HI", HI, 32'h0);
    check("no late commit LO", LO, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 8)), pick_val(), pick_val(), st);
    end
    for (int i = 0; i < DC + 2; i++) cyc(1'b1, 4'd0, 32'h0, 32'h0, st);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
